// File: rtl/nn_pkg.sv
// Shared sizing, lane type and FSM encoding for the chunked dot-product sequencer.
package nn_pkg;

    localparam int W          = 8;
    localparam int MUL        = 27;
    localparam int NUM_CHUNKS = 35;
    localparam int CW         = $clog2(NUM_CHUNKS);

    // Result width that holds the sum of mul full-range signed w x w products.
    function automatic int acc_width(input int w, input int mul);
        return 2 * w + $clog2(mul);
    endfunction

    localparam int ACC_W = acc_width(W, MUL);

    typedef logic signed [W-1:0] lane_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_dot_seq_dot_tree.sv
// MUL-lane signed multiply (stage 2) followed by an adder tree into the
// result register (stage 3). Both stages advance only on en, and a tag
// rides alongside the data so the caller can track index/last/valid.
module dot_tree
    import nn_pkg::*;
#(
    parameter int TW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [TW-1:0]    in_tag,
    input  logic [MUL*W-1:0] in_w,
    input  logic [MUL*W-1:0] in_a,
    output logic             out_valid,
    output logic [TW-1:0]    out_tag,
    output logic [ACC_W-1:0] out_sum
);

    localparam int PW = 2 * W;

    logic signed [PW-1:0] prod_s [MUL];
    logic signed [PW-1:0] prod_r [MUL];
    logic                 s2_valid_r;
    logic [TW-1:0]        s2_tag_r;
    logic [ACC_W-1:0]     sum_s;
    logic                 s3_valid_r;
    logic [TW-1:0]        s3_tag_r;
    logic [ACC_W-1:0]     s3_sum_r;

    // Both operands are sign-extended to product width so the low PW bits
    // of the multiply are the exact signed product.
    for (genvar i = 0; i < MUL; i++) begin : g_lane
        logic signed [PW-1:0] w_ext_s;
        logic signed [PW-1:0] a_ext_s;
        assign w_ext_s   = {{W{in_w[i*W+W-1]}}, in_w[i*W +: W]};
        assign a_ext_s   = {{W{in_a[i*W+W-1]}}, in_a[i*W +: W]};
        assign prod_s[i] = w_ext_s * a_ext_s;
    end

    // Sum the registered products, each sign-extended to the result width.
    always_comb begin
        sum_s = {ACC_W{1'b0}};
        for (int i = 0; i < MUL; i++) begin
            sum_s = sum_s + {{(ACC_W-PW){prod_r[i][PW-1]}}, prod_r[i]};
        end
    end

    // Stage 2: capture products; data only moves when a valid chunk arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_tag_r   <= {TW{1'b0}};
            for (int i = 0; i < MUL; i++) begin
                prod_r[i] <= {PW{1'b0}};
            end
        end else if (en) begin
            s2_valid_r <= in_valid;
            if (in_valid) begin
                s2_tag_r <= in_tag;
                for (int i = 0; i < MUL; i++) begin
                    prod_r[i] <= prod_s[i];
                end
            end
        end
    end

    // Stage 3: capture the reduced sum as the visible result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_r <= 1'b0;
            s3_tag_r   <= {TW{1'b0}};
            s3_sum_r   <= {ACC_W{1'b0}};
        end else if (en) begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                s3_tag_r <= s2_tag_r;
                s3_sum_r <= sum_s;
            end
        end
    end

    assign out_valid = s3_valid_r;
    assign out_tag   = s3_tag_r;
    assign out_sum   = s3_sum_r;

endmodule

// File: rtl/chunk_dot_seq.sv
// Walks COUNT chunks of the weight memory starting at BASE (wrapping at
// NUM_CHUNKS), dots each chunk with a latched activation vector and
// streams one signed result per chunk over a valid/ready port.
module chunk_dot_seq
    import nn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    base,
    input  logic [CW:0]      count,
    input  logic [MUL*W-1:0] act,
    output logic             busy,
    output logic             done,
    output logic             mem_rp_load,
    output logic [CW-1:0]    mem_rp_val,
    output logic             mem_rp_inc,
    input  logic [MUL*W-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CW-1:0]    out_idx,
    output logic             out_last
);

    localparam logic [CW:0] ONE_C  = {{CW{1'b0}}, 1'b1};
    localparam logic [CW:0] WRAP_C = (CW+1)'(NUM_CHUNKS);

    state_t           state_r;
    state_t           state_nx_s;
    logic [CW-1:0]    cur_idx_r;
    logic [CW:0]      issued_r;
    logic [CW:0]      count_r;
    logic [MUL*W-1:0] act_r;
    logic             done_r;
    logic             busy_r;
    logic             s1_valid_r;
    logic [CW-1:0]    s1_idx_r;
    logic             s1_last_r;

    logic             adv_s;
    logic             start_job_s;
    logic             start_zero_s;
    logic             last_hs_s;
    logic [CW:0]      idx_inc_s;
    logic             wrap_s;
    logic             rp_load_s;
    logic [CW-1:0]    rp_val_s;
    logic             rp_inc_s;
    logic             issue_s;
    logic [CW-1:0]    issue_idx_s;
    logic             issue_last_s;

    assign adv_s        = !out_valid || out_ready;
    assign start_job_s  = (state_r == ST_IDLE) && start && (count != {(CW+1){1'b0}});
    assign start_zero_s = (state_r == ST_IDLE) && start && (count == {(CW+1){1'b0}});
    assign last_hs_s    = (state_r == ST_DRAIN) && out_valid && out_ready && out_last;
    assign idx_inc_s    = {1'b0, cur_idx_r} + ONE_C;
    assign wrap_s       = (idx_inc_s == WRAP_C);

    // Next state plus the per-cycle read-pointer command and issue tag.
    always_comb begin
        state_nx_s   = state_r;
        rp_load_s    = 1'b0;
        rp_val_s     = {CW{1'b0}};
        rp_inc_s     = 1'b0;
        issue_s      = 1'b0;
        issue_idx_s  = cur_idx_r;
        issue_last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_job_s) begin
                    state_nx_s   = ST_RUN;
                    rp_load_s    = 1'b1;
                    rp_val_s     = base;
                    issue_s      = 1'b1;
                    issue_idx_s  = base;
                    issue_last_s = (count == ONE_C);
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issued_r == count_r) begin
                    state_nx_s = ST_DRAIN;
                end else if (adv_s) begin
                    issue_s      = 1'b1;
                    issue_last_s = ((issued_r + ONE_C) == count_r);
                    if (wrap_s) begin
                        rp_load_s   = 1'b1;
                        rp_val_s    = {CW{1'b0}};
                        issue_idx_s = {CW{1'b0}};
                    end else begin
                        rp_inc_s    = 1'b1;
                        issue_idx_s = idx_inc_s[CW-1:0];
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (last_hs_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Job bookkeeping: last issued index, issue count, latched job inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_idx_r <= {CW{1'b0}};
            issued_r  <= {(CW+1){1'b0}};
            count_r   <= {(CW+1){1'b0}};
            act_r     <= {(MUL*W){1'b0}};
        end else begin
            if (start_job_s) begin
                count_r <= count;
                act_r   <= act;
            end
            if (issue_s) begin
                cur_idx_r <= issue_idx_s;
                issued_r  <= (state_r == ST_IDLE) ? ONE_C : (issued_r + ONE_C);
            end
        end
    end

    // Status outputs: busy follows the FSM, done pulses once per finished job.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= start_zero_s || last_hs_s;
        end
    end

    // Stage-1 tag tracks the chunk the memory is presenting on mem_rdata;
    // while stalled the memory re-reads the same chunk, so the tag holds too.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_idx_r   <= {CW{1'b0}};
            s1_last_r  <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= issue_s;
            s1_idx_r   <= issue_idx_s;
            s1_last_r  <= issue_last_s;
        end
    end

    dot_tree #(
        .TW (CW + 1)
    ) u_dot_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (adv_s),
        .in_valid  (s1_valid_r),
        .in_tag    ({s1_idx_r, s1_last_r}),
        .in_w      (mem_rdata),
        .in_a      (act_r),
        .out_valid (out_valid),
        .out_tag   ({out_idx, out_last}),
        .out_sum   (out_data)
    );

    // The pointer command must reach the memory in the start cycle itself,
    // so it is combinational and forced quiet while reset is applied.
    assign mem_rp_load = rp_load_s & ~rst;
    assign mem_rp_val  = rp_val_s;
    assign mem_rp_inc  = rp_inc_s & ~rst;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_chunk_dot_seq.sv
// Directed bench for chunk_dot_seq with a behavioural chunked read memory.
`timescale 1ns/1ps
module tb_chunk_dot_seq;
    import nn_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CW-1:0]    base;
    logic [CW:0]      count;
    logic [MUL*W-1:0] act;
    logic             busy, done, mem_rp_load, mem_rp_inc;
    logic [CW-1:0]    mem_rp_val;
    logic [MUL*W-1:0] mem_rdata = '0;
    logic             out_valid, out_ready, out_last;
    logic [ACC_W-1:0] out_data;
    logic [CW-1:0]    out_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    chunk_dot_seq dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .count(count), .act(act),
        .busy(busy), .done(done), .mem_rp_load(mem_rp_load), .mem_rp_val(mem_rp_val),
        .mem_rp_inc(mem_rp_inc), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    // Chunked memory: registered read, data for a new pointer shows next cycle.
    logic [MUL*W-1:0] mem [NUM_CHUNKS];
    logic [CW-1:0]    rp = '0;
    always @(posedge clk) begin
        if (mem_rp_load) begin
            rp        <= mem_rp_val;
            mem_rdata <= mem[mem_rp_val];
        end else if (mem_rp_inc) begin
            rp        <= rp + 6'd1;
            mem_rdata <= mem[rp + 6'd1];
        end else begin
            mem_rdata <= mem[rp];
        end
    end

    logic [15:0] pat = 16'b1110_1011_0100_1111;
    logic signed [63:0] r_data[$], r_idx[$], r_last[$], r_cyc[$];
    int load_cnt, wrap_cnt, done_cyc;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int c, input int v);
        logic [W-1:0] b;
        b = W'(v);
        for (int i = 0; i < MUL; i++) mem[c][i*W +: W] = b;
    endtask

    task automatic act_all(input int v);
        logic [W-1:0] b;
        b = W'(v);
        for (int i = 0; i < MUL; i++) act[i*W +: W] = b;
    endtask

    // Drive start in the current cycle, check the pointer load, leave in cycle 1.
    task automatic start_job(input int b, input int n, input int av, input bit exp_load);
        start = 1'b1;
        base  = CW'(b);
        count = (CW+1)'(n);
        act_all(av);
        out_ready = 1'b1;
        #1;
        chk("rp_load_at_start", mem_rp_load, exp_load);
        if (exp_load) chk("rp_val_at_start", mem_rp_val, b);
        tick();
        start = 1'b0;
        act_all(85);
    endtask

    // Run cycles until done (bounded), recording accepted results and checking holds.
    task automatic collect(input int first_c, input int max_c, input bit use_pat);
        bit got_done, prev_stall;
        logic signed [63:0] p_data, p_idx, p_last;
        r_data.delete(); r_idx.delete(); r_last.delete(); r_cyc.delete();
        load_cnt = 0; wrap_cnt = 0; done_cyc = -1;
        got_done = 1'b0; prev_stall = 1'b0;
        p_data = 0; p_idx = 0; p_last = 0;
        for (int c = first_c; c <= max_c && !got_done; c++) begin
            out_ready = use_pat ? pat[c % 16] : 1'b1;
            #1;
            if (mem_rp_load) begin
                load_cnt++;
                if (mem_rp_val == '0) wrap_cnt++;
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", $signed(out_data), p_data);
                chk("hold_idx", out_idx, p_idx);
                chk("hold_last", out_last, p_last);
            end
            if (out_valid && out_ready) begin
                r_data.push_back($signed(out_data));
                r_idx.push_back(out_idx);
                r_last.push_back(out_last);
                r_cyc.push_back(c);
            end
            prev_stall = out_valid && !out_ready;
            p_data = $signed(out_data); p_idx = out_idx; p_last = out_last;
            if (done) begin
                got_done = 1'b1;
                done_cyc = c;
            end
            tick();
        end
        out_ready = 1'b1;
        chk("job_done_seen", got_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; count = '0; act = '0; out_ready = 1'b1;
        for (int c = 0; c < NUM_CHUNKS; c++) fill(c, 0);
        fill(3, 1);
        repeat (3) tick();
        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_rp_load", mem_rp_load, 0);
        chk("rst_rp_inc", mem_rp_inc, 0);
        rst = 1'b0;
        tick();

        // 1: single chunk, latency and done timing
        start_job(3, 1, 2, 1);
        chk("t1_busy", busy, 1);
        collect(1, 20, 0);
        chk("t1_nres", r_data.size(), 1);
        if (r_data.size() == 1) begin
            chk("t1_cycle", r_cyc[0], 3);
            chk("t1_data", r_data[0], 54);
            chk("t1_idx", r_idx[0], 3);
            chk("t1_last", r_last[0], 1);
        end
        chk("t1_done_cycle", done_cyc, 4);
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);

        // 2: signed extremes
        fill(0, -128);
        start_job(0, 1, -128, 1);
        collect(1, 20, 0);
        chk("t2_nres_a", r_data.size(), 1);
        if (r_data.size() == 1) chk("t2_neg_neg", r_data[0], 442368);
        fill(1, 127);
        start_job(1, 1, -1, 1);
        collect(1, 20, 0);
        chk("t2_nres_b", r_data.size(), 1);
        if (r_data.size() == 1) chk("t2_pos_neg", r_data[0], -3429);

        // 3: wrap at end of memory, back-to-back results
        fill(33, 1); fill(34, 2); fill(0, 3); fill(1, 4);
        start_job(33, 4, 1, 1);
        collect(1, 30, 0);
        chk("t3_nres", r_data.size(), 4);
        chk("t3_wrap_load", wrap_cnt, 1);
        chk("t3_load_cnt", load_cnt, 1);
        for (int k = 0; k < r_data.size() && k < 4; k++) begin
            chk("t3_idx", r_idx[k], (33 + k) % 35);
            chk("t3_data", r_data[k], 27 * (k + 1));
            chk("t3_last", r_last[k], (k == 3) ? 1 : 0);
            chk("t3_cycle", r_cyc[k], 3 + k);
        end

        // 4: backpressure
        for (int k = 0; k < 5; k++) fill(5 + k, k + 1);
        start_job(5, 5, 1, 1);
        collect(1, 60, 1);
        chk("t4_nres", r_data.size(), 5);
        for (int k = 0; k < r_data.size() && k < 5; k++) begin
            chk("t4_idx", r_idx[k], 5 + k);
            chk("t4_data", r_data[k], 27 * (k + 1));
            chk("t4_last", r_last[k], (k == 4) ? 1 : 0);
        end

        // 5: empty job, then start while busy
        start_job(0, 0, 1, 0);
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_novalid", out_valid, 0);
        chk("t5_noload", mem_rp_load, 0);
        tick();
        chk("t5_done_pulse", done, 0);
        fill(10, 2); fill(11, 3);
        start_job(10, 2, 1, 1);
        chk("t5_busy_job", busy, 1);
        start = 1'b1; base = CW'(20); count = (CW+1)'(3); act_all(5);
        #1;
        chk("t5_busy_start_noload", mem_rp_load, 0);
        tick();
        start = 1'b0;
        collect(2, 30, 0);
        chk("t5_nres", r_data.size(), 2);
        chk("t5_loads", load_cnt, 0);
        for (int k = 0; k < r_data.size() && k < 2; k++) begin
            chk("t5_idx", r_idx[k], 10 + k);
            chk("t5_data", r_data[k], 27 * (k + 2));
            chk("t5_last", r_last[k], (k == 1) ? 1 : 0);
        end

        // 6: reset mid-job, then a fresh job
        start_job(0, 8, 1, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_valid", out_valid, 0);
        tick();
        start_job(3, 1, 2, 1);
        collect(1, 20, 0);
        chk("t6_nres", r_data.size(), 1);
        if (r_data.size() == 1) begin
            chk("t6_data", r_data[0], 54);
            chk("t6_idx", r_idx[0], 3);
            chk("t6_cycle", r_cyc[0], 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
